// File: rtl/adsr_pkg.sv
// Shared types and constants for the ADSR envelope voice.
// State encoding, default envelope width and the gated-state helper.
package adsr_pkg;

    localparam int ENV_WIDTH_DEF = 16;
    localparam int ENV_MAX       = (2 ** ENV_WIDTH_DEF) - 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } adsr_state_t;

    // States that fall into RELEASE as soon as the gate drops.
    function automatic logic is_gated_state(input adsr_state_t s);
        logic r;
        case (s)
            ATTACK, DECAY, SUSTAIN: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/adsr_vca.sv
// Two-stage VCA: multiplies a signed sample by the unsigned envelope level
// captured on the sample tick and presents the upper product half.
module adsr_vca #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ENV_WIDTH    = 16
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           sample_tick,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic        [ENV_WIDTH-1:0]    level_in,
    output logic signed [SAMPLE_WIDTH-1:0] sample_out,
    output logic                           sample_valid_out
);

    localparam int PROD_W = SAMPLE_WIDTH + ENV_WIDTH + 1;

    logic signed [PROD_W-1:0] product_s;
    logic signed [PROD_W-1:0] product_r;
    logic                     stage1_valid_r;
    logic                     prod_sign_unused_s;

    // The level is zero-extended so the multiply stays signed without ever overflowing.
    assign product_s          = sample_in * $signed({1'b0, level_in});
    assign prod_sign_unused_s = product_r[PROD_W-1];

    // Product register, then output register; a reset drops anything in flight.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            product_r        <= {PROD_W{1'b0}};
            stage1_valid_r   <= 1'b0;
            sample_out       <= {SAMPLE_WIDTH{1'b0}};
            sample_valid_out <= 1'b0;
        end else begin
            if (sample_tick) begin
                product_r <= product_s;
            end
            stage1_valid_r <= sample_tick;
            if (stage1_valid_r) begin
                sample_out <= product_r[ENV_WIDTH +: SAMPLE_WIDTH];
            end
            sample_valid_out <= stage1_valid_r;
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator with trigger latch, level register and VCA.
// Optional feature macro: ADSR_EXP_RELEASE_EN selects exponential release.
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int SAMPLE_WIDTH  = 16,
    parameter int ENV_WIDTH     = ENV_WIDTH_DEF,
    parameter int RELEASE_SHIFT = 6
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           sample_tick,
    input  logic                           gate_in,
    input  logic                           trigger_in,
    input  logic        [ENV_WIDTH-1:0]    attack_step,
    input  logic        [ENV_WIDTH-1:0]    decay_step,
    input  logic        [ENV_WIDTH-1:0]    sustain_level,
    input  logic        [ENV_WIDTH-1:0]    release_step,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    output logic signed [SAMPLE_WIDTH-1:0] sample_out,
    output logic                           sample_valid_out,
    output logic        [ENV_WIDTH-1:0]    env_level_out,
    output logic        [2:0]              state_out,
    output logic                           active_out
);

    localparam logic [ENV_WIDTH-1:0] ENV_MAX_L  = {ENV_WIDTH{1'b1}};
    localparam logic [ENV_WIDTH-1:0] ENV_ZERO_L = {ENV_WIDTH{1'b0}};

    adsr_state_t          state_r;
    adsr_state_t          state_nxt_s;
    logic [ENV_WIDTH-1:0] level_r;
    logic [ENV_WIDTH-1:0] level_nxt_s;
    logic                 trig_pend_r;
    logic                 trig_pend_nxt_s;
    logic                 trig_eff_s;
    logic                 active_r;

    logic [ENV_WIDTH:0]   atk_sum_s;
    logic [ENV_WIDTH:0]   dec_diff_s;
    logic [ENV_WIDTH:0]   rel_amount_s;
    logic [ENV_WIDTH:0]   rel_diff_s;
    logic                 atk_done_s;
    logic                 dec_done_s;
    logic                 rel_done_s;
    logic [ENV_WIDTH-1:0] atk_level_s;
    logic [ENV_WIDTH-1:0] dec_level_s;
    logic [ENV_WIDTH-1:0] rel_level_s;

    // A trigger arriving on the tick cycle itself is honoured at that tick.
    assign trig_eff_s = trig_pend_r | trigger_in;

    // Trigger latch: set by any trigger pulse, consumed by the next tick.
    always_comb begin
        trig_pend_nxt_s = trig_pend_r;
        if (sample_tick) begin
            trig_pend_nxt_s = 1'b0;
        end else begin
            trig_pend_nxt_s = trig_pend_r | trigger_in;
        end
    end

    // Attack step with carry detection; a zero step jumps straight to full scale.
    always_comb begin
        atk_sum_s  = {1'b0, level_r} + {1'b0, attack_step};
        atk_done_s = (attack_step == ENV_ZERO_L) || atk_sum_s[ENV_WIDTH]
                     || (atk_sum_s[ENV_WIDTH-1:0] == ENV_MAX_L);
        if (atk_done_s) begin
            atk_level_s = ENV_MAX_L;
        end else begin
            atk_level_s = atk_sum_s[ENV_WIDTH-1:0];
        end
    end

    // Decay step with borrow detection, clamped to the sustain level.
    always_comb begin
        dec_diff_s = {1'b0, level_r} - {1'b0, decay_step};
        dec_done_s = (decay_step == ENV_ZERO_L) || dec_diff_s[ENV_WIDTH]
                     || (dec_diff_s[ENV_WIDTH-1:0] <= sustain_level);
        if (dec_done_s) begin
            dec_level_s = sustain_level;
        end else begin
            dec_level_s = dec_diff_s[ENV_WIDTH-1:0];
        end
    end

`ifdef ADSR_EXP_RELEASE_EN
    logic rel_step_unused_s;
    // The +1 keeps the exponential tail from stalling above zero.
    assign rel_amount_s      = ({1'b0, level_r} >> RELEASE_SHIFT) + {{ENV_WIDTH{1'b0}}, 1'b1};
    assign rel_step_unused_s = ^release_step;
`else
    logic [7:0] rel_shift_unused_s;
    assign rel_amount_s       = {1'b0, release_step};
    assign rel_shift_unused_s = 8'(RELEASE_SHIFT);
`endif

    // Release step floored at zero; reaching zero ends the note.
    always_comb begin
        rel_diff_s = {1'b0, level_r} - rel_amount_s;
        rel_done_s = (rel_amount_s == {(ENV_WIDTH + 1){1'b0}}) || rel_diff_s[ENV_WIDTH]
                     || (rel_diff_s[ENV_WIDTH-1:0] == ENV_ZERO_L);
        if (rel_done_s) begin
            rel_level_s = ENV_ZERO_L;
        end else begin
            rel_level_s = rel_diff_s[ENV_WIDTH-1:0];
        end
    end

    // Envelope FSM: retrigger beats gate-off, which beats the state's own rule.
    always_comb begin
        state_nxt_s = state_r;
        level_nxt_s = level_r;
        if (sample_tick) begin
            if (trig_eff_s && gate_in) begin
                level_nxt_s = atk_level_s;
                if (atk_done_s) begin
                    state_nxt_s = DECAY;
                end else begin
                    state_nxt_s = ATTACK;
                end
            end else if (!gate_in && is_gated_state(state_r)) begin
                level_nxt_s = rel_level_s;
                if (rel_done_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RELEASE;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        level_nxt_s = ENV_ZERO_L;
                    end
                    ATTACK: begin
                        level_nxt_s = atk_level_s;
                        if (atk_done_s) begin
                            state_nxt_s = DECAY;
                        end else begin
                            state_nxt_s = ATTACK;
                        end
                    end
                    DECAY: begin
                        level_nxt_s = dec_level_s;
                        if (dec_done_s) begin
                            state_nxt_s = SUSTAIN;
                        end else begin
                            state_nxt_s = DECAY;
                        end
                    end
                    SUSTAIN: begin
                        level_nxt_s = sustain_level;
                    end
                    RELEASE: begin
                        level_nxt_s = rel_level_s;
                        if (rel_done_s) begin
                            state_nxt_s = IDLE;
                        end else begin
                            state_nxt_s = RELEASE;
                        end
                    end
                    default: begin
                        state_nxt_s = IDLE;
                        level_nxt_s = ENV_ZERO_L;
                    end
                endcase
            end
        end else begin
            state_nxt_s = state_r;
            level_nxt_s = level_r;
        end
    end

    // State, level, trigger latch and activity flag registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r     <= IDLE;
            level_r     <= ENV_ZERO_L;
            trig_pend_r <= 1'b0;
            active_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            level_r     <= level_nxt_s;
            trig_pend_r <= trig_pend_nxt_s;
            active_r    <= (state_nxt_s != IDLE);
        end
    end

    assign env_level_out = level_r;
    assign state_out     = state_r;
    assign active_out    = active_r;

    // The VCA sees the level as it was before this tick's update.
    adsr_vca #(
        .SAMPLE_WIDTH(SAMPLE_WIDTH),
        .ENV_WIDTH   (ENV_WIDTH)
    ) u_vca (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sample_tick     (sample_tick),
        .sample_in       (sample_in),
        .level_in        (level_r),
        .sample_out      (sample_out),
        .sample_valid_out(sample_valid_out)
    );

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed scenarios plus randomized
// stimulus against an integer reference model of the envelope and VCA.
module tb_adsr_envelope;

    localparam int ENV_TOP   = 65535;
    localparam int REL_SHIFT = 6;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b1;
    logic               sample_tick = 1'b0;
    logic               gate_in = 1'b0;
    logic               trigger_in = 1'b0;
    logic        [15:0] attack_step = 16'd0;
    logic        [15:0] decay_step = 16'd0;
    logic        [15:0] sustain_level = 16'd0;
    logic        [15:0] release_step = 16'd0;
    logic signed [15:0] sample_in = 16'sd0;
    logic signed [15:0] sample_out;
    logic               sample_valid_out;
    logic        [15:0] env_level_out;
    logic        [2:0]  state_out;
    logic               active_out;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    adsr_envelope #(
        .SAMPLE_WIDTH (16),
        .ENV_WIDTH    (16),
        .RELEASE_SHIFT(REL_SHIFT)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sample_tick     (sample_tick),
        .gate_in         (gate_in),
        .trigger_in      (trigger_in),
        .attack_step     (attack_step),
        .decay_step      (decay_step),
        .sustain_level   (sustain_level),
        .release_step    (release_step),
        .sample_in       (sample_in),
        .sample_out      (sample_out),
        .sample_valid_out(sample_valid_out),
        .env_level_out   (env_level_out),
        .state_out       (state_out),
        .active_out      (active_out)
    );

    // Reference model: state 0..4 = idle/attack/decay/sustain/release.
    typedef struct {
        int due;
        int val;
    } vca_t;

    int   m_state = 0;
    int   m_level = 0;
    bit   m_pend  = 1'b0;
    bit   m_vld   = 1'b0;
    int   m_out   = 0;
    int   cyc     = 0;
    vca_t m_q[$];

    function automatic void m_attack();
        if (attack_step == 16'd0) m_level = ENV_TOP;
        else if (m_level + int'(attack_step) > ENV_TOP) m_level = ENV_TOP;
        else m_level = m_level + int'(attack_step);
        if (m_level == ENV_TOP) m_state = 2;
    endfunction

    function automatic void m_decay();
        int n;
        int sus;
        sus = sustain_level;
        n = m_level - int'(decay_step);
        if (decay_step == 16'd0 || n <= sus) begin
            m_level = sus;
            m_state = 3;
        end else begin
            m_level = n;
        end
    endfunction

    function automatic void m_release();
        int dec;
        int n;
`ifdef ADSR_EXP_RELEASE_EN
        dec = (m_level >> REL_SHIFT) + 1;
`else
        dec = release_step;
`endif
        n = m_level - dec;
        if (dec == 0 || n <= 0) begin
            m_level = 0;
            m_state = 0;
        end else begin
            m_level = n;
        end
    endfunction

    function automatic void model_edge();
        longint p;
        bit     trig;
        cyc++;
        while (m_q.size() > 0 && m_q[0].due < cyc) void'(m_q.pop_front());
        if (rst_in) begin
            m_state = 0; m_level = 0; m_pend = 1'b0;
            m_vld = 1'b0; m_out = 0; m_q.delete();
        end else begin
            m_vld = (m_q.size() > 0 && m_q[0].due == cyc);
            if (m_vld) m_out = m_q[0].val;
            if (sample_tick) begin
                p = longint'(sample_in) * longint'(m_level);
                m_q.push_back('{due: cyc + 1, val: int'(p >>> 16)});
                trig = m_pend || trigger_in;
                m_pend = 1'b0;
                if (trig && gate_in) begin
                    m_state = 1;
                    m_attack();
                end else if (!gate_in && m_state >= 1 && m_state <= 3) begin
                    m_state = 4;
                    m_release();
                end else begin
                    case (m_state)
                        1: m_attack();
                        2: m_decay();
                        3: m_level = sustain_level;
                        4: m_release();
                        default: m_level = 0;
                    endcase
                end
            end else if (trigger_in) begin
                m_pend = 1'b1;
            end
        end
    endfunction

    task automatic drive(input bit tk, input bit gt, input bit tr, input int smp);
        sample_tick = tk;
        gate_in     = gt;
        trigger_in  = tr;
        sample_in   = 16'(smp);
        @(posedge clk_in);
        model_edge();
        #1;
        sample_tick = 1'b0;
        trigger_in  = 1'b0;
    endtask

    task automatic tick_gap(input bit gt, input int smp);
        for (int i = 0; i < 3; i++) drive(1'b0, gt, 1'b0, 0);
        drive(1'b1, gt, 1'b0, smp);
    endtask

    task automatic apply_reset();
        rst_in = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 0);
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 0);
        total++; if (env_level_out !== 16'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", env_level_out); end
        total++; if (state_out !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state_out); end
        total++; if (active_out !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", active_out); end
        total++; if (sample_out !== 16'sd0) begin bad++; $display("FAIL reset_sample: got %0d want 0", sample_out); end
        total++; if (sample_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", sample_valid_out); end
        rst_in = 1'b0;
    endtask

    task automatic test_attack();
        int exp_lv[4] = '{16384, 32768, 49152, 65535};
        int exp_st[4] = '{1, 1, 1, 2};
        attack_step = 16'd16384; decay_step = 16'd8192;
        sustain_level = 16'd20000; release_step = 16'd10000;
        drive(1'b0, 1'b1, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            tick_gap(1'b1, 0);
            total++; if (env_level_out !== 16'(exp_lv[i])) begin bad++; $display("FAIL attack_level[%0d]: got %0d want %0d", i, env_level_out, exp_lv[i]); end
            total++; if (state_out !== 3'(exp_st[i])) begin bad++; $display("FAIL attack_state[%0d]: got %0d want %0d", i, state_out, exp_st[i]); end
        end
        total++; if (active_out !== 1'b1) begin bad++; $display("FAIL attack_active: got %b want 1", active_out); end
    endtask

    task automatic test_decay_sustain();
        int exp_lv[6] = '{57343, 49151, 40959, 32767, 24575, 20000};
        int exp_st[6] = '{2, 2, 2, 2, 2, 3};
        for (int i = 0; i < 6; i++) begin
            tick_gap(1'b1, 0);
            total++; if (env_level_out !== 16'(exp_lv[i])) begin bad++; $display("FAIL decay_level[%0d]: got %0d want %0d", i, env_level_out, exp_lv[i]); end
            total++; if (state_out !== 3'(exp_st[i])) begin bad++; $display("FAIL decay_state[%0d]: got %0d want %0d", i, state_out, exp_st[i]); end
        end
        sustain_level = 16'd30000;
        tick_gap(1'b1, 0);
        total++; if (env_level_out !== 16'd30000) begin bad++; $display("FAIL sustain_track: got %0d want 30000", env_level_out); end
        total++; if (state_out !== 3'd3) begin bad++; $display("FAIL sustain_state: got %0d want 3", state_out); end
    endtask

`ifndef ADSR_EXP_RELEASE_EN
    task automatic test_release();
        int exp_lv[3] = '{20000, 10000, 0};
        int exp_st[3] = '{4, 4, 0};
        for (int i = 0; i < 3; i++) begin
            tick_gap(1'b0, 0);
            total++; if (env_level_out !== 16'(exp_lv[i])) begin bad++; $display("FAIL release_level[%0d]: got %0d want %0d", i, env_level_out, exp_lv[i]); end
            total++; if (state_out !== 3'(exp_st[i])) begin bad++; $display("FAIL release_state[%0d]: got %0d want %0d", i, state_out, exp_st[i]); end
        end
        total++; if (active_out !== 1'b0) begin bad++; $display("FAIL release_active: got %b want 0", active_out); end
    endtask

    task automatic test_retrigger();
        attack_step = 16'd20000;
        drive(1'b0, 1'b1, 1'b1, 0);
        tick_gap(1'b1, 0);
        release_step = 16'd5000;
        tick_gap(1'b0, 0);
        total++; if (env_level_out !== 16'd15000 || state_out !== 3'd4) begin bad++; $display("FAIL retrig_setup: got %0d/%0d want 15000/4", env_level_out, state_out); end
        attack_step = 16'd1000;
        drive(1'b0, 1'b1, 1'b1, 0);
        tick_gap(1'b1, 0);
        total++; if (env_level_out !== 16'd16000) begin bad++; $display("FAIL retrig_level: got %0d want 16000", env_level_out); end
        total++; if (state_out !== 3'd1) begin bad++; $display("FAIL retrig_state: got %0d want 1", state_out); end
        drive(1'b0, 1'b0, 1'b1, 0);
        tick_gap(1'b0, 0);
        tick_gap(1'b1, 0);
        total++; if (env_level_out !== 16'd6000) begin bad++; $display("FAIL gate_low_trig_level: got %0d want 6000", env_level_out); end
        total++; if (state_out !== 3'd4) begin bad++; $display("FAIL gate_low_trig_state: got %0d want 4", state_out); end
    endtask
`endif

    task automatic test_vca();
        apply_reset();
        attack_step = 16'd0; decay_step = 16'd32767;
        sustain_level = 16'd32768; release_step = 16'hFFFF;
        drive(1'b0, 1'b1, 1'b1, 0);
        tick_gap(1'b1, 0);
        total++; if (env_level_out !== 16'hFFFF || state_out !== 3'd2) begin bad++; $display("FAIL vca_zero_attack: got %0d/%0d want 65535/2", env_level_out, state_out); end
        tick_gap(1'b1, -32768);
        total++; if (sample_valid_out !== 1'b0) begin bad++; $display("FAIL vca_valid_early: got %b want 0", sample_valid_out); end
        drive(1'b0, 1'b1, 1'b0, 0);
        total++; if (sample_valid_out !== 1'b1) begin bad++; $display("FAIL vca_valid_on_time: got %b want 1", sample_valid_out); end
        total++; if (sample_out !== -16'sd32768) begin bad++; $display("FAIL vca_full_scale: got %0d want -32768", sample_out); end
        drive(1'b0, 1'b1, 1'b0, 0);
        total++; if (sample_valid_out !== 1'b0) begin bad++; $display("FAIL vca_valid_late: got %b want 0", sample_valid_out); end
        tick_gap(1'b1, -32768);
        drive(1'b0, 1'b1, 1'b0, 0);
        total++; if (sample_out !== -16'sd16384) begin bad++; $display("FAIL vca_half: got %0d want -16384", sample_out); end
        tick_gap(1'b1, 12345);
        drive(1'b0, 1'b1, 1'b0, 0);
        total++; if (sample_out !== 16'sd6172) begin bad++; $display("FAIL vca_pos_half: got %0d want 6172", sample_out); end
        tick_gap(1'b1, -1);
        drive(1'b0, 1'b1, 1'b0, 0);
        total++; if (sample_out !== -16'sd1) begin bad++; $display("FAIL vca_floor: got %0d want -1", sample_out); end
        for (int i = 0; i < 2000 && state_out !== 3'd0; i++) drive(1'b1, 1'b0, 1'b0, 30000);
        total++; if (state_out !== 3'd0) begin bad++; $display("FAIL vca_release_timeout: got state %0d want 0", state_out); end
        drive(1'b1, 1'b0, 1'b0, 30000);
        drive(1'b0, 1'b0, 1'b0, 0);
        total++; if (sample_valid_out !== 1'b1 || sample_out !== 16'sd0) begin bad++; $display("FAIL vca_level_zero: got %0d valid %b want 0 valid 1", sample_out, sample_valid_out); end
    endtask

`ifdef ADSR_EXP_RELEASE_EN
    task automatic test_exp_release();
        int exp_lv[2] = '{629, 619};
        apply_reset();
        attack_step = 16'd640;
        drive(1'b0, 1'b1, 1'b1, 0);
        tick_gap(1'b1, 0);
        total++; if (env_level_out !== 16'd640) begin bad++; $display("FAIL exp_setup: got %0d want 640", env_level_out); end
        for (int i = 0; i < 2; i++) begin
            tick_gap(1'b0, 0);
            total++; if (env_level_out !== 16'(exp_lv[i]) || state_out !== 3'd4) begin bad++; $display("FAIL exp_level[%0d]: got %0d/%0d want %0d/4", i, env_level_out, state_out, exp_lv[i]); end
        end
        for (int i = 0; i < 2000 && state_out !== 3'd0; i++) drive(1'b1, 1'b0, 1'b0, 0);
        total++; if (state_out !== 3'd0 || env_level_out !== 16'd0) begin bad++; $display("FAIL exp_reach_zero: got %0d/%0d want 0/0", env_level_out, state_out); end
    endtask
`endif

    task automatic test_reset_mid_note();
        apply_reset();
        attack_step = 16'd1000;
        drive(1'b0, 1'b1, 1'b1, 0);
        tick_gap(1'b1, 0);
        drive(1'b1, 1'b1, 1'b0, 100);
        rst_in = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 0);
        total++; if (env_level_out !== 16'd0 || state_out !== 3'd0 || active_out !== 1'b0) begin bad++; $display("FAIL midnote_reset: got %0d/%0d/%b want 0/0/0", env_level_out, state_out, active_out); end
        total++; if (sample_out !== 16'sd0 || sample_valid_out !== 1'b0) begin bad++; $display("FAIL midnote_reset_vca: got %0d valid %b want 0 valid 0", sample_out, sample_valid_out); end
        rst_in = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 0);
        total++; if (sample_valid_out !== 1'b0) begin bad++; $display("FAIL midnote_valid_dropped: got %b want 0", sample_valid_out); end
    endtask

    task automatic test_random();
        bit r_gate = 1'b0;
        apply_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                attack_step   = ($urandom_range(0, 8) == 0) ? 16'd0 : 16'($urandom_range(1, 20000));
                decay_step    = ($urandom_range(0, 8) == 0) ? 16'd0 : 16'($urandom_range(1, 12000));
                release_step  = ($urandom_range(0, 8) == 0) ? 16'd0 : 16'($urandom_range(1, 12000));
            end
            if ($urandom_range(0, 39) == 0) sustain_level = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 29) == 0) r_gate = !r_gate;
            rst_in = ($urandom_range(0, 999) == 0);
            drive($urandom_range(0, 3) == 0, r_gate, $urandom_range(0, 24) == 0,
                  int'($urandom_range(0, 65535)) - 32768);
            total++; if (env_level_out !== 16'(m_level)) begin bad++; $display("FAIL rand_level @%0d: got %0d want %0d", n, env_level_out, m_level); end
            total++; if (state_out !== 3'(m_state)) begin bad++; $display("FAIL rand_state @%0d: got %0d want %0d", n, state_out, m_state); end
            total++; if (active_out !== (m_state != 0)) begin bad++; $display("FAIL rand_active @%0d: got %b want %b", n, active_out, m_state != 0); end
            total++; if (sample_valid_out !== m_vld) begin bad++; $display("FAIL rand_valid @%0d: got %b want %b", n, sample_valid_out, m_vld); end
            if (m_vld) begin
                total++; if (sample_out !== 16'(m_out)) begin bad++; $display("FAIL rand_sample @%0d: got %0d want %0d", n, sample_out, m_out); end
            end
        end
        rst_in = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_attack();
        test_decay_sustain();
`ifndef ADSR_EXP_RELEASE_EN
        test_release();
        test_retrigger();
`else
        test_exp_release();
`endif
        test_vca();
        test_reset_mid_note();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
